id_ex_bubble_register: RTL

- ID/EX pipeline register for the 5-stage MIPS core.
- Consumes the hazard detector's bubble request: a bubble zeroes the control bits entering EX.
- Produces the EX-stage load flag and RT address that the hazard detector compares against the instruction in ID.
- Also supports a global freeze (memory stall) and a flush, and keeps a saturating count of injected bubbles.

---
 rtl/id_ex_bubble_register_if.sv | 45 ++++
 rtl/id_ex_bubble_register.sv | 81 ++++++++
 2 files changed

// File: rtl/id_ex_bubble_register_if.sv
// ID/EX boundary bundle: ID-side inputs, EX-side registered outputs and
// the hazard-detector feedback (load flag and RT address).
interface id_ex_bubble_register_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic                     stall_i;
  logic                     flush_i;
  logic                     bubble_i;
  logic [8:0]               ctrl_i;
  logic signed [DATA_W-1:0] rs_data_i;
  logic signed [DATA_W-1:0] rt_data_i;
  logic signed [DATA_W-1:0] imm_i;
  logic [4:0]               rs_addr_i;
  logic [4:0]               rt_addr_i;
  logic [4:0]               rd_addr_i;

  logic [8:0]               ctrl_o;
  logic signed [DATA_W-1:0] rs_data_o;
  logic signed [DATA_W-1:0] rt_data_o;
  logic signed [DATA_W-1:0] imm_o;
  logic [4:0]               rs_addr_o;
  logic [4:0]               rt_addr_o;
  logic [4:0]               rd_addr_o;
  logic                     mem_read_o;
  logic [4:0]               rt_hazard_o;
  logic                     valid_o;
  logic [CNT_W-1:0]         bubble_cnt_o;

  // Driven by the ID stage / hazard unit
  modport master (
    output stall_i, flush_i, bubble_i, ctrl_i,
    output rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
    input  ctrl_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o,
    input  mem_read_o, rt_hazard_o, valid_o, bubble_cnt_o
  );

  // The pipeline register itself
  modport slave (
    input  stall_i, flush_i, bubble_i, ctrl_i,
    input  rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
    output ctrl_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o,
    output mem_read_o, rt_hazard_o, valid_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_bubble_register.sv
// ID/EX pipeline register with bubble injection, flush, global freeze and a
// saturating bubble counter. Hazard feedback comes only from registered state.
module id_ex_bubble_register #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  id_ex_bubble_register_if.slave  bus
);

  localparam int MEM_READ_BIT = 6;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + CNT_W'(1);
  endfunction

  logic                     kill_p0;
  logic [8:0]               ctrl_p0;
  logic                     vld_p0;
  logic [CNT_W-1:0]         cnt_p0;

  logic [8:0]               ctrl_p1;
  logic                     vld_p1;
  logic [CNT_W-1:0]         cnt_p1;
  logic signed [DATA_W-1:0] rs_data_p1;
  logic signed [DATA_W-1:0] rt_data_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [4:0]               rs_addr_p1;
  logic [4:0]               rt_addr_p1;
  logic [4:0]               rd_addr_p1;

  // ---- p0: next-state selection (stall is handled at the register enable)
  always_comb begin
    kill_p0 = bus.flush_i | bus.bubble_i;
    ctrl_p0 = kill_p0 ? 9'd0 : bus.ctrl_i;
    vld_p0  = ~kill_p0;
    // A flush outranks the bubble, so a squashed slot is not counted
    cnt_p0  = (bus.bubble_i && !bus.flush_i) ? sat_inc(cnt_p1) : cnt_p1;
  end

  // ---- p1: ID/EX register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_p1    <= '0;
      vld_p1     <= 1'b0;
      cnt_p1     <= '0;
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      imm_p1     <= '0;
      rs_addr_p1 <= '0;
      rt_addr_p1 <= '0;
      rd_addr_p1 <= '0;
    end else if (!bus.stall_i) begin
      ctrl_p1    <= ctrl_p0;
      vld_p1     <= vld_p0;
      cnt_p1     <= cnt_p0;
      rs_data_p1 <= bus.rs_data_i;
      rt_data_p1 <= bus.rt_data_i;
      imm_p1     <= bus.imm_i;
      rs_addr_p1 <= bus.rs_addr_i;
      rt_addr_p1 <= bus.rt_addr_i;
      rd_addr_p1 <= bus.rd_addr_i;
    end
  end

  assign bus.ctrl_o       = ctrl_p1;
  assign bus.valid_o      = vld_p1;
  assign bus.bubble_cnt_o = cnt_p1;
  assign bus.rs_data_o    = rs_data_p1;
  assign bus.rt_data_o    = rt_data_p1;
  assign bus.imm_o        = imm_p1;
  assign bus.rs_addr_o    = rs_addr_p1;
  assign bus.rt_addr_o    = rt_addr_p1;
  assign bus.rd_addr_o    = rd_addr_p1;
  // RT is only a hazard source when EX holds a load
  assign bus.mem_read_o   = ctrl_p1[MEM_READ_BIT];
  assign bus.rt_hazard_o  = ctrl_p1[MEM_READ_BIT] ? rt_addr_p1 : 5'd0;

endmodule
